// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port synchronous RAM with a one-cycle registered read.
// Optional range-zeroing command is enabled with `define MEM_BURST_MASTER_CLEAR_EN.
module mem_burst_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
`ifdef MEM_BURST_MASTER_CLEAR_EN
    input  logic                  cmd_clear,
`endif
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
`ifdef MEM_BURST_MASTER_CLEAR_EN
        ST_CLEAR,
`endif
        ST_DRAIN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [LEN_WIDTH-1:0]  count_reg, count_next;
    logic                  mem_we_reg, mem_we_next;
    logic [ADDR_WIDTH-1:0] mem_address_reg, mem_address_next;
    logic [DATA_WIDTH-1:0] mem_data_reg, mem_data_next;
    // issue_reg marks an address on the RAM pins this cycle; rd_valid_reg marks its data returning.
    logic                  issue_reg, issue_next;
    logic                  rd_valid_reg;

    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        count_next       = count_reg;
        mem_we_next      = 1'b0;
        mem_address_next = mem_address_reg;
        mem_data_next    = mem_data_reg;
        issue_next       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_next  = cmd_addr;
                    count_next = cmd_len;
`ifdef MEM_BURST_MASTER_CLEAR_EN
                    if (cmd_clear)
                        state_next = ST_CLEAR;
                    else
`endif
                    if (cmd_write)
                        state_next = ST_WRITE;
                    else
                        state_next = ST_READ;
                end
            end
            ST_WRITE: begin
                if (wr_valid) begin
                    mem_we_next      = 1'b1;
                    mem_address_next = addr_reg;
                    mem_data_next    = wr_data;
                    addr_next        = addr_reg + ADDR_ONE;
                    count_next       = count_reg - LEN_ONE;
                    if (count_reg == '0)
                        state_next = ST_IDLE;
                end
            end
            ST_READ: begin
                mem_address_next = addr_reg;
                issue_next       = 1'b1;
                addr_next        = addr_reg + ADDR_ONE;
                count_next       = count_reg - LEN_ONE;
                if (count_reg == '0)
                    state_next = ST_DRAIN;
            end
`ifdef MEM_BURST_MASTER_CLEAR_EN
            ST_CLEAR: begin
                mem_we_next      = 1'b1;
                mem_address_next = addr_reg;
                mem_data_next    = '0;
                addr_next        = addr_reg + ADDR_ONE;
                count_next       = count_reg - LEN_ONE;
                if (count_reg == '0)
                    state_next = ST_IDLE;
            end
`endif
            ST_DRAIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            addr_reg        <= '0;
            count_reg       <= '0;
            mem_we_reg      <= 1'b0;
            mem_address_reg <= '0;
            mem_data_reg    <= '0;
            issue_reg       <= 1'b0;
            rd_valid_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            count_reg       <= count_next;
            mem_we_reg      <= mem_we_next;
            mem_address_reg <= mem_address_next;
            mem_data_reg    <= mem_data_next;
            issue_reg       <= issue_next;
            rd_valid_reg    <= issue_reg;
        end
    end

    assign cmd_ready   = (state_reg == ST_IDLE);
    assign wr_ready    = (state_reg == ST_WRITE);
    assign rd_valid    = rd_valid_reg;
    assign rd_data     = mem_rdata;
    assign busy        = (state_reg != ST_IDLE) || issue_reg || rd_valid_reg;
    assign mem_address = mem_address_reg;
    assign mem_data    = mem_data_reg;
    assign mem_we      = mem_we_reg;

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural RAM and strobe/read scoreboards.
module tb_mem_burst_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
`ifdef MEM_BURST_MASTER_CLEAR_EN
    logic        cmd_clear;
`endif
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_data;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        busy;
    logic [15:0] mem_address;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    mem_burst_master dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
`ifdef MEM_BURST_MASTER_CLEAR_EN
        .cmd_clear(cmd_clear),
`endif
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
        .mem_address(mem_address), .mem_data(mem_data), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] ram   [0:65535];
    logic [7:0] model [0:65535];

    always @(posedge clk) begin
        if (mem_we === 1'b1) ram[mem_address] <= mem_data;
        mem_rdata <= ram[mem_address];
    end

    typedef struct { logic [15:0] addr; logic [7:0] data; int cyc; } wexp_t;
    typedef struct { logic [7:0] data; int cyc; } rexp_t;
    wexp_t wq[$];
    rexp_t rq[$];

    int total = 0;
    int bad = 0;
    int cycle_cnt = 0;
    int strobe_cnt = 0;
    int rd_cnt = 0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            strobe_cnt++;
            total++;
            assert (wq.size() != 0) else begin
                bad++; $error("FAIL wr_unexpected observed addr=%h data=%h expected none", mem_address, mem_data);
            end
            if (wq.size() != 0) begin
                wexp_t e;
                e = wq.pop_front();
                total++;
                assert ({mem_address, mem_data} === {e.addr, e.data}) else begin
                    bad++; $error("FAIL wr_beat observed=%h/%h expected=%h/%h", mem_address, mem_data, e.addr, e.data);
                end
                total++;
                assert (cycle_cnt === e.cyc) else begin
                    bad++; $error("FAIL wr_cycle observed=%0d expected=%0d", cycle_cnt, e.cyc);
                end
                $display("write strobe addr=%h data=%h cycle=%0d", mem_address, mem_data, cycle_cnt);
            end
        end
        if (rd_valid === 1'b1) begin
            rd_cnt++;
            total++;
            assert (rq.size() != 0) else begin
                bad++; $error("FAIL rd_unexpected observed data=%h expected none", rd_data);
            end
            if (rq.size() != 0) begin
                rexp_t r;
                r = rq.pop_front();
                total++;
                assert (rd_data === r.data) else begin
                    bad++; $error("FAIL rd_data observed=%h expected=%h", rd_data, r.data);
                end
                total++;
                assert (cycle_cnt === r.cyc) else begin
                    bad++; $error("FAIL rd_cycle observed=%0d expected=%0d", cycle_cnt, r.cyc);
                end
                $display("read beat data=%h cycle=%0d", rd_data, cycle_cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++; $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [15:0] a, input logic [7:0] l, output int c0);
        int n;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = l;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("cmd_accept_timeout", {31'd0, cmd_ready}, 32'd1);
        c0 = cycle_cnt + 1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] l, input logic [7:0] base, input int gap);
        int c0;
        send_cmd(1'b1, a, l, c0);
        for (int i = 0; i <= int'(l); i++) begin
            logic [15:0] ba;
            logic [7:0]  d;
            if (i == gap) begin
                wr_valid = 1'b0;
                tick();
            end
            ba = a + 16'(i);
            d  = base + 8'(i);
            check("wr_ready", {31'd0, wr_ready}, 32'd1);
            wr_valid = 1'b1;
            wr_data  = d;
            wq.push_back('{addr: ba, data: d, cyc: cycle_cnt + 1});
            model[ba] = d;
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] l);
        int c0;
        send_cmd(1'b0, a, l, c0);
        for (int i = 0; i <= int'(l); i++) begin
            logic [15:0] ba;
            ba = a + 16'(i);
            rq.push_back('{data: model[ba], cyc: c0 + 2 + i});
        end
    endtask

`ifdef MEM_BURST_MASTER_CLEAR_EN
    task automatic do_clear(input logic [15:0] a, input logic [7:0] l);
        int c0;
        cmd_clear = 1'b1;
        send_cmd(1'b1, a, l, c0);
        cmd_clear = 1'b0;
        for (int i = 0; i <= int'(l); i++) begin
            logic [15:0] ba;
            ba = a + 16'(i);
            wq.push_back('{addr: ba, data: 8'h00, cyc: c0 + 1 + i});
            model[ba] = 8'h00;
        end
        for (int i = 0; i <= int'(l); i++) begin
            check("clear_wr_ready", {31'd0, wr_ready}, 32'd0);
            tick();
        end
    endtask
`endif

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || wq.size() != 0 || rq.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        check("idle_timeout", {busy, 15'd0, 8'(wq.size()), 8'(rq.size())}, 32'd0);
    endtask

    task automatic check_reset_state();
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_address", {16'd0, mem_address}, 32'd0);
        check("rst_mem_data", {24'd0, mem_data}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int r0;
        int c0;
        int c1;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
`ifdef MEM_BURST_MASTER_CLEAR_EN
        cmd_clear = 1'b0;
`endif
        cmd_addr  = 16'h0;
        cmd_len   = 8'h0;
        wr_valid  = 1'b0;
        wr_data   = 8'h0;
        tick();
        tick();
        check_reset_state();
        $display("reset state checked");
        reset = 1'b1;
        tick();

        // Write with a wr_valid gap, then read it back.
        s0 = strobe_cnt;
        do_write(16'h0010, 8'd3, 8'hA1, 2);
        wait_idle();
        check("write_strobe_count", 32'(strobe_cnt - s0), 32'd4);
        s0 = strobe_cnt;
        r0 = rd_cnt;
        do_read(16'h0010, 8'd3);
        wait_idle();
        check("read_beat_count", 32'(rd_cnt - r0), 32'd4);
        check("read_no_strobe", 32'(strobe_cnt - s0), 32'd0);

        // Address wrap, read issued immediately after the last write handshake.
        do_write(16'hFFFE, 8'd3, 8'h11, -1);
        do_read(16'hFFFE, 8'd3);
        wait_idle();

        // One-beat reads with cmd_valid held high.
        do_write(16'h0005, 8'd0, 8'h5A, -1);
        wait_idle();
        r0 = rd_cnt;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0005;
        cmd_len   = 8'd0;
        check("len0_ready_first", {31'd0, cmd_ready}, 32'd1);
        c0 = cycle_cnt + 1;
        tick();
        rq.push_back('{data: model[16'h0005], cyc: c0 + 2});
        check("len0_ready_read", {31'd0, cmd_ready}, 32'd0);
        tick();
        check("len0_ready_drain", {31'd0, cmd_ready}, 32'd0);
        tick();
        check("len0_ready_back", {31'd0, cmd_ready}, 32'd1);
        c1 = cycle_cnt + 1;
        check("len0_spacing", 32'(c1 - c0), 32'd3);
        tick();
        cmd_valid = 1'b0;
        rq.push_back('{data: model[16'h0005], cyc: c1 + 2});
        wait_idle();
        check("len0_beat_count", 32'(rd_cnt - r0), 32'd2);

`ifdef MEM_BURST_MASTER_CLEAR_EN
        do_clear(16'h0010, 8'd3);
        wait_idle();
        r0 = rd_cnt;
        do_read(16'h0010, 8'd3);
        wait_idle();
        check("clear_read_count", 32'(rd_cnt - r0), 32'd4);
`endif

        // Reset in the middle of an 8-beat write burst.
        s0 = strobe_cnt;
        send_cmd(1'b1, 16'h0100, 8'd7, c0);
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'hC0 + 8'(i);
            wq.push_back('{addr: 16'h0100 + 16'(i), data: wr_data, cyc: cycle_cnt + 1});
            model[16'h0100 + 16'(i)] = wr_data;
            tick();
        end
        reset    = 1'b0;
        wr_data  = 8'hEE;
        tick();
        check_reset_state();
        reset    = 1'b1;
        wr_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("abandoned_strobe_count", 32'(strobe_cnt - s0), 32'd2);
        do_read(16'h0100, 8'd1);
        wait_idle();
        $display("reset mid-burst checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
